pulse_press_gen: RTL and testbench

//  Inverse of the button synchronizer: converts one-cycle strobes into clean
//  "button press" levels. Each accepted strobe produces a high level of exactly

---
 rtl/pulse_press_gen.sv | 112 +++++++++++
 tb/tb_pulse_press_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pulse_press_gen.sv
// pulse_press_gen: turns one-cycle press strobes into clean button-press levels.
// Each press holds Lo high for HOLD_CYCLES cycles, then holds it low for
// GAP_CYCLES cycles so a downstream edge detector always sees a release.
// Strobes arriving while a press is in progress are queued (up to MAX_PEND);
// strobes beyond that are dropped and flagged on Ovf for one cycle.
module pulse_press_gen #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int MAX_PEND    = 3,
    localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES,
    localparam int CW     = $clog2(MAX_HG + 1),
    localparam int PW     = $clog2(MAX_PEND + 1)
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Pi,
    output logic          Lo,
    output logic          Busy,
    output logic [PW-1:0] Pending,
    output logic          Ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [PW-1:0] pending_next;
    logic          ovf_next;

    logic          busy_int;
    logic          hold_last;
    logic          gap_last;
    logic          consume;
    logic          accept;

    // Outputs decoded directly from state so an async reset clears Lo at once
    assign busy_int = (state != IDLE);
    assign Lo       = (state == HOLD);
    assign Busy     = busy_int;

    // State, phase counter, queue depth and overflow flag registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            Pending <= '0;
            Ovf     <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            Pending <= pending_next;
            Ovf     <= ovf_next;
        end
    end

    // Next-state, queue accounting and drop detection
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pending_next = Pending;
        ovf_next     = 1'b0;

        hold_last = (state == HOLD) && (cnt == CW'(HOLD_CYCLES - 1));
        gap_last  = (state == GAP)  && (cnt == CW'(GAP_CYCLES - 1));

        // A press is available at the end of the gap if one is queued or a
        // strobe arrives in that same cycle; a full queue can still take the
        // new strobe because one entry leaves as it arrives.
        consume = gap_last && ((Pending != '0) || Pi);
        accept  = Pi && busy_int && ((Pending < PW'(MAX_PEND)) || consume);

        pending_next = Pending + PW'(accept) - PW'(consume);
        ovf_next     = Pi && busy_int && !accept;

        case (state)
            IDLE: begin
                // Strobe seen while idle starts a press directly, never queued
                if (Pi) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            end
            HOLD: begin
                if (hold_last) begin
                    state_next = GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            GAP: begin
                if (gap_last) begin
                    state_next = consume ? HOLD : IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pulse_press_gen.sv
// Directed bench for pulse_press_gen with HOLD=4, GAP=2, MAX_PEND=3.
// Expected values at "cycle n" are what the outputs show just before the
// nth posedge after the first strobe, i.e. sampled 1 time unit after edge n-1.
module tb_pulse_press_gen;

    logic       Clock;
    logic       Resetn;
    logic       Pi;
    logic       Lo;
    logic       Busy;
    logic [1:0] Pending;
    logic       Ovf;

    int checks;
    int errors;
    int pend_exp [0:63];

    pulse_press_gen #(
        .HOLD_CYCLES(4),
        .GAP_CYCLES (2),
        .MAX_PEND   (3)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Pi     (Pi),
        .Lo     (Lo),
        .Busy   (Busy),
        .Pending(Pending),
        .Ovf    (Ovf)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input int idx, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_pend;
        for (int i = 0; i < 64; i++) pend_exp[i] = 0;
    endtask

    task automatic fill_pend(input int lo_n, input int hi_n, input int val);
        for (int i = lo_n; i <= hi_n; i++) pend_exp[i] = val;
    endtask

    // Drive pi[k] for edges k=0..n and check outputs on cycles 1..n+1
    task automatic run(input string tag, input int n, input logic [63:0] pi,
                       input logic [63:0] lo, input logic [63:0] busy,
                       input logic [63:0] ovf);
        for (int k = 0; k <= n; k++) begin
            Pi = pi[k];
            tick();
            chk({tag, ".lo"},   k + 1, int'(Lo),      int'(lo[k+1]));
            chk({tag, ".busy"}, k + 1, int'(Busy),    int'(busy[k+1]));
            chk({tag, ".ovf"},  k + 1, int'(Ovf),     int'(ovf[k+1]));
            chk({tag, ".pend"}, k + 1, int'(Pending), pend_exp[k+1]);
        end
        Pi = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Pi     = 1'b0;
        Resetn = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst.lo",   0, int'(Lo),      0);
        chk("rst.busy", 0, int'(Busy),    0);
        chk("rst.pend", 0, int'(Pending), 0);
        chk("rst.ovf",  0, int'(Ovf),     0);
        #3;
        Resetn = 1'b1;

        // 1: single strobe
        clear_pend();
        run("t1", 8, 64'h1, 64'h1E, 64'h7E, 64'h0);

        // 2: second strobe queued during HOLD
        clear_pend();
        fill_pend(3, 6, 1);
        run("t2", 13, 64'h5, 64'h79E, 64'h1FFE, 64'h0);

        // 3: six back-to-back strobes, queue fills, two dropped
        clear_pend();
        fill_pend(2, 2, 1);
        fill_pend(3, 3, 2);
        fill_pend(4, 6, 3);
        fill_pend(7, 12, 2);
        fill_pend(13, 18, 1);
        run("t3", 25, 64'h3F, 64'h79E79E, 64'h1FFFFFE, 64'h60);

        // 4: strobe on the last GAP cycle with empty queue
        clear_pend();
        run("t4", 13, 64'h41, 64'h79E, 64'h1FFE, 64'h0);

        // 6: full queue plus strobe on the last GAP cycle is accepted
        clear_pend();
        fill_pend(2, 2, 1);
        fill_pend(3, 3, 2);
        fill_pend(4, 12, 3);
        fill_pend(13, 18, 2);
        fill_pend(19, 24, 1);
        run("t6", 31, 64'h4F, 64'h1E79E79E, 64'h7FFFFFFE, 64'h0);

        // 5: asynchronous reset in the middle of HOLD with a queued press
        Pi = 1'b1;
        tick();
        tick();
        Pi = 1'b0;
        tick();
        chk("t5.pre.lo",   2, int'(Lo),      1);
        chk("t5.pre.pend", 2, int'(Pending), 1);
        #4;
        Resetn = 1'b0;
        #1;
        chk("t5.async.lo",   0, int'(Lo),      0);
        chk("t5.async.busy", 0, int'(Busy),    0);
        chk("t5.async.pend", 0, int'(Pending), 0);
        tick();
        chk("t5.held.lo", 0, int'(Lo), 0);
        #3;
        Resetn = 1'b1;
        clear_pend();
        run("t5.after", 8, 64'h1, 64'h1E, 64'h7E, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
